// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 codes, FSM state encoding, op-class helper.
// Used by muldiv_unit (optional MULDIV_EARLY_OUT_EN) and muldiv_step.
package riscv_m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // All divide/remainder encodings have funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3 >= F3_DIV;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// trial-subtract for divide, on a {hi, lo} working register pair.
module muldiv_step
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            is_div_op,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
        shifted = {hi_in, lo_in[XLEN-1]};
        // Remainder stays below the divisor, so diff[XLEN] is exactly the borrow.
        diff    = shifted - {1'b0, operand};
        if (is_div_op) begin
            hi_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_out = {lo_in[XLEN-2:0], ~diff[XLEN]};
        end else begin
            hi_out = sum[XLEN:1];
            lo_out = {sum[0], lo_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one step per cycle, one-cycle write-back pulse.
// Define MULDIV_EARLY_OUT_EN to finish trivial multiplies/divides through the FIX path.
module muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic            write_enable,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result,
    output logic [1:0]      state_dbg
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [4:0]      rd_q, rd_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0]   step_hi, step_lo;
    logic              a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              special, early;
    logic [XLEN-1:0]   special_val;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo, rem, final_val;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_op (is_div(funct3_q)),
        .hi_in     (hi_q),
        .lo_in     (lo_q),
        .operand   (opnd_q),
        .hi_out    (step_hi),
        .lo_out    (step_lo)
    );

    always_comb begin
        a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                   (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa    = a_signed & op_a[XLEN-1];
        sb    = b_signed & op_b[XLEN-1];
        mag_a = sa ? -op_a : op_a;
        mag_b = sb ? -op_b : op_b;

        early = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        early = is_div(funct3) ? ((op_b != '0) && (mag_a < mag_b))
                               : ((op_a == '0) || (op_b == '0));
`endif

        special     = 1'b0;
        special_val = '0;
        if (is_div(funct3) && (op_b == '0)) begin
            special     = 1'b1;
            special_val = funct3[1] ? op_a : '1;
        end else if ((funct3 == F3_DIV || funct3 == F3_REM) &&
                     (op_a == MIN_NEG) && (op_b == '1)) begin
            special     = 1'b1;
            special_val = funct3[1] ? '0 : MIN_NEG;
        end else if (early) begin
            special     = 1'b1;
            special_val = (is_div(funct3) && funct3[1]) ? op_a : '0;
        end
    end

    // Final sign fix-up and selection, taken from the last iteration's outputs.
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        quo      = neg_q ? -step_lo : step_lo;
        rem      = neg_rem_q ? -step_hi : step_hi;
        if (is_div(funct3_q)) begin
            final_val = funct3_q[1] ? rem : quo;
        end else begin
            final_val = (funct3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        funct3_d  = funct3_q;
        rd_d      = rd_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    funct3_d  = funct3;
                    rd_d      = rd_in;
                    neg_d     = sa ^ sb;
                    neg_rem_d = sa;
                    hi_d      = '0;
                    cnt_d     = CW'(XLEN);
                    // Divide iterates on the dividend; multiply shifts out the multiplier.
                    if (is_div(funct3)) begin
                        lo_d   = mag_a;
                        opnd_d = mag_b;
                    end else begin
                        lo_d   = mag_b;
                        opnd_d = mag_a;
                    end
                    if (special) begin
                        result_d = special_val;
                        state_d  = ST_FIX;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = final_val;
                    state_d  = ST_SIGN;
                end
            end
            ST_SIGN: state_d = ST_IDLE;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opnd_q    <= opnd_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_SIGN) || (state_q == ST_FIX);
    assign write_enable = done && (rd_q != 5'd0);
    assign rd_out       = rd_q;
    assign result       = result_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M vectors, latency,
// ignored start, rd=0 suppression and mid-operation reset.
module tb_muldiv_unit;
    import riscv_m_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done, write_enable;
    logic [4:0]  rd_out;
    logic [31:0] result;
    logic [1:0]  state_dbg;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .funct3       (funct3),
        .op_a         (op_a),
        .op_b         (op_b),
        .rd_in        (rd_in),
        .busy         (busy),
        .done         (done),
        .write_enable (write_enable),
        .rd_out       (rd_out),
        .result       (result),
        .state_dbg    (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for one cycle, then scramble the inputs so latching is exercised.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_done(input int first_cyc, output int lat);
        int cyc = first_cyc;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(f, a, b, rd);
        wait_done(1, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp);
        check({tag, "_rd"}, 32'(rd_out), 32'(rd));
        check({tag, "_we"}, 32'(write_enable), 32'(rd != 5'd0));
        @(negedge clk);
        check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;

        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);

        run_op("mul_7_m3",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
        run_op("mulhu_ff",    F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
        run_op("mulh_ff",     F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33);
        run_op("mulhsu_ff",   F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33);
        run_op("mulh_min",    F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd9,  32'h4000_0000, 33);
        run_op("div_m7_2",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",    F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF, 33);
        run_op("div_20_m6",   F3_DIV,    32'd20,         32'hFFFF_FFFA, 5'd12, 32'hFFFF_FFFD, 33);
        run_op("rem_20_m6",   F3_REM,    32'd20,         32'hFFFF_FFFA, 5'd13, 32'd2,         33);
        run_op("divu_100_7",  F3_DIVU,   32'd100,        32'd7,         5'd14, 32'd14,        33);
        run_op("remu_100_7",  F3_REMU,   32'd100,        32'd7,         5'd15, 32'd2,         33);
        run_op("divu_max_1",  F3_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd16, 32'hFFFF_FFFF, 33);
        run_op("remu_max_16", F3_REMU,   32'hFFFF_FFFF,  32'd16,        5'd17, 32'h0000_000F, 33);
        run_op("div_5_0",     F3_DIV,    32'd5,          32'd0,         5'd18, 32'hFFFF_FFFF, 1);
        run_op("rem_5_0",     F3_REM,    32'd5,          32'd0,         5'd19, 32'd5,         1);
        run_op("divu_5_0",    F3_DIVU,   32'd5,          32'd0,         5'd20, 32'hFFFF_FFFF, 1);
        run_op("div_ovf",     F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1);
        run_op("rem_ovf",     F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd22, 32'd0,         1);
        run_op("rd0_mulhu",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 33);

        // A second start ten cycles into a running divide must be dropped.
        issue(F3_DIVU, 32'd100, 32'd7, 5'd3);
        repeat (9) @(negedge clk);
        start  = 1'b1;
        funct3 = F3_MUL;
        op_a   = 32'd2;
        op_b   = 32'd3;
        rd_in  = 5'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, lat);
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_res", result, 32'd14);
        check("ign_rd", 32'(rd_out), 32'd3);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("ign_single_done", 32'(ndone), 32'd0);

        // Reset fifteen cycles into a multiply aborts it without a write-back.
        issue(F3_MUL, 32'd7, 32'd3, 5'd1);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_rd", 32'(rd_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);
        run_op("post_rst_mul", F3_MUL, 32'd7, 32'd3, 5'd4, 32'd21, 33);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the no-pipeline core.
- Consumes the two source operands from the ID-stage register read ports, and the destination index.
- Produces a one-cycle write-back pulse (result, rd, write enable) to the register controller's write port.
- Holds the core (busy) while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value (from register controller out_one).
- op_b  input  XLEN  rs2 value (from register controller out_two).
- rd_in  input  5  destination register index.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result and rd_out valid.
- write_enable  output  1  equals done AND (rd_out != 0).
- rd_out  output  5  latched rd_in.
- result  output  XLEN  operation result; held until the next accepted start.

Behaviour:
- Reset: async, active-high. State goes to IDLE. busy, done, write_enable = 0; result = 0; rd_out = 0; all internal registers cleared.
- Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: start=1 latches funct3, rd_in and operand magnitudes/sign flags, plus iteration counter = XLEN. Goes to CALC, or to FIX for special divide cases.
  - CALC: one shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements. At counter==1 goes to SIGN.
  - SIGN: applies result negation, selects hi/lo or quotient/remainder, drives done=1 for this cycle only, then returns to IDLE.
  - FIX: drives the special result with done=1, then returns to IDLE.
- Latency: start accepted at cycle T; done at T+XLEN+1 (33 cycles) for normal ops, T+1 for special cases.
- start while busy=1 is ignored; no queueing.
- Operands are latched at acceptance; later changes on op_a/op_b have no effect.
- Multiply: unsigned 2*XLEN product of magnitudes, negated if the effective signs differ.
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
  - Signedness: MULH treats both operands signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned.
- Divide: restoring division on magnitudes.
  - Quotient is negated if signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases (FIX path):
  - op_b == 0: DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed overflow (op_a = 0x80000000, op_b = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- write_enable is suppressed for rd=0 (x0 writes are discarded anyway; this avoids a redundant write).
- done and start in the same cycle: the unit is in SIGN/FIX, not IDLE, so that start is ignored; the issuer must wait for busy=0.

Optional Feature:
- MULDIV_EARLY_OUT_EN.
- Defined: a multiply with op_a==0 or op_b==0 takes the FIX path and returns 0 at T+1.
- Defined: a divide with |op_a| < |op_b| (magnitudes, non-zero divisor) takes the FIX path. DIV/DIVU return 0; REM/REMU return op_a.
- Undefined: every non-special op takes the full XLEN+1 cycles.

Decomposition:
- Package riscv_m_pkg holds:
  - funct3 constants (F3_MUL..F3_REMU)
  - state encoding (ST_IDLE, ST_CALC, ST_SIGN, ST_FIX)
  - helper function is_div(funct3) = funct3[2]
- One sub-module, muldiv_step: combinational single iteration.
  - Multiply: conditional add + shift.
  - Divide: trial subtract + quotient-bit shift.
  - Instantiated once in CALC.

Test Plan:
- MUL 7 * -3 (op_a=7, op_b=0xFFFFFFFD), rd=5 -> done at T+33, result=0xFFFFFFEB, write_enable=1, rd_out=5.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
- DIV -7 / 2 -> result=0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF at T+1; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000; REM 0x80000000 / -1 -> 0.
- start pulsed at T+10 of a running op -> ignored, single done; rd=0 op -> done=1, write_enable=0.
- Reset asserted at T+15 -> busy=0, result=0 immediately; no done; a new start after release completes normally.
